// File: rtl/sig_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sig_gen_pkg
// Brief    : Shared types and default widths for the sine-ROM address path.
// Revision : 1.0 - initial release
// ============================================================================
package sig_gen_pkg;

    localparam int c_acc_width     = 16;
    localparam int c_address_width = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/phase_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : phase_accumulator
// Brief    : Modulo-2^ACC_WIDTH phase accumulator with carry-out wrap event.
// Revision : 1.0 - initial release
// ============================================================================
module phase_accumulator
    import sig_gen_pkg::*;
#(
    parameter int ACC_WIDTH = c_acc_width
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [ACC_WIDTH-1:0] incr,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 wrap_evt
);

    logic [ACC_WIDTH:0]   w_sum;
    logic [ACC_WIDTH-1:0] r_acc;

    assign w_sum    = {1'b0, r_acc} + {1'b0, incr};
    // The carry only counts as a wrap when the sum is actually committed.
    assign wrap_evt = en & w_sum[ACC_WIDTH];
    assign acc      = r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= w_sum[ACC_WIDTH-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/phase_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : phase_addr_gen
// Brief    : Dual-port sine ROM address generator; addr2 = addr1 + offset,
//            offset changes deferred to accumulator wrap while running.
//            Optional macro WRAP_PULSE_EN adds a registered wrap pulse output.
// Revision : 1.0 - initial release
// ============================================================================
module phase_addr_gen
    import sig_gen_pkg::*;
#(
    parameter int ADDRESS_WIDTH = c_address_width,
    parameter int ACC_WIDTH     = c_acc_width
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [ACC_WIDTH-1:0]     incr,
    input  logic [ADDRESS_WIDTH-1:0] offset,
    input  logic                     offset_valid,
    output logic                     offset_ready,
    output logic [ADDRESS_WIDTH-1:0] addr1,
`ifdef WRAP_PULSE_EN
    output logic [ADDRESS_WIDTH-1:0] addr2,
    output logic                     wrap
`else
    output logic [ADDRESS_WIDTH-1:0] addr2
`endif
);

    logic [ACC_WIDTH-1:0]     w_acc;
    logic                     w_wrap_evt;
    logic [ADDRESS_WIDTH-1:0] w_phase;
    logic                     w_xfer;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ADDRESS_WIDTH-1:0] r_offset_q;
    logic [ADDRESS_WIDTH-1:0] w_offset_nxt;
    logic [ADDRESS_WIDTH-1:0] r_pending;
    logic [ADDRESS_WIDTH-1:0] w_pending_nxt;

    phase_accumulator #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_acc (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .incr     (incr),
        .acc      (w_acc),
        .wrap_evt (w_wrap_evt)
    );

    assign w_phase      = w_acc[ACC_WIDTH-1 -: ADDRESS_WIDTH];
    assign offset_ready = (r_state != PEND);
    assign w_xfer       = offset_valid & offset_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_offset_nxt  = r_offset_q;
        w_pending_nxt = r_pending;
        case (r_state)
            IDLE: begin
                // Nothing is sweeping, so the new offset can take effect at once.
                if (w_xfer) begin
                    w_offset_nxt = offset;
                end
                if (en) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_xfer) begin
                    w_pending_nxt = offset;
                    w_state_nxt   = PEND;
                end else if (!en) begin
                    w_state_nxt = IDLE;
                end
            end
            PEND: begin
                if (!en) begin
                    w_offset_nxt = r_pending;
                    w_state_nxt  = IDLE;
                end else if (w_wrap_evt) begin
                    w_offset_nxt = r_pending;
                    w_state_nxt  = RUN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_offset_q <= '0;
            r_pending  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_offset_q <= w_offset_nxt;
            r_pending  <= w_pending_nxt;
        end
    end

    // Both addresses come from the same acc/offset snapshot so they never skew.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr1 <= '0;
            addr2 <= '0;
        end else begin
            addr1 <= w_phase;
            addr2 <= w_phase + r_offset_q;
        end
    end

`ifdef WRAP_PULSE_EN
    logic r_wrap_d1;

    // Two stages: one for acc to take the wrapped value, one for addr1 to show it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap_d1 <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            r_wrap_d1 <= w_wrap_evt;
            wrap      <= r_wrap_d1;
        end
    end
`endif

endmodule
`default_nettype wire
